// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit sequencer: CPU writes into an external FIFO, bytes are drained one at a time into the TX shifter.
// Optional watermark interrupt enabled by defining UART_TX_WATERMARK_EN (adds wm_level input).
module uart_tx_fifo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              tx_en,
  output logic              cpu_wready,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  level,
  output logic              drained,
`ifdef UART_TX_WATERMARK_EN
  input  logic [CNT_W-1:0]  wm_level,
`endif
  output logic              fifo_writeEn,
  output logic [DATA_W-1:0] fifo_dataIn,
  output logic              fifo_readEn,
  input  logic [DATA_W-1:0] fifo_dataOut,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              irq_wm
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] LEVEL_MAX = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, GAP} state_t;

  state_t            state, state_nxt;
  logic              rd_nxt;
  logic              start_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              wr_acc;

  assign wr_acc       = cpu_wr & ~fifo_full;
  assign fifo_writeEn = wr_acc;
  assign fifo_dataIn  = cpu_wdata;
  assign cpu_wready   = ~fifo_full;
  assign drained      = fifo_empty & (state == IDLE);

  always_comb begin
    state_nxt = state;
    rd_nxt    = 1'b0;
    start_nxt = 1'b0;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty && !tx_busy) begin
          rd_nxt    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        start_nxt = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (tx_done) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            gap_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // fifo_readEn and tx_start are registered so each is a clean single-cycle pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      fifo_readEn <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      fifo_readEn <= rd_nxt;
      tx_start    <= start_nxt;
      gap_cnt     <= gap_nxt;
      if (state == LOAD) begin
        tx_data <= fifo_dataOut;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= '0;
    end else begin
      case ({wr_acc, fifo_readEn})
        2'b10: if (level != LEVEL_MAX) level <= level + 1'b1;
        2'b01: if (level != '0) level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A new overflow wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (cpu_wr && fifo_full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_wm <= 1'b0;
    end else if (level <= wm_level && tx_en) begin
      irq_wm <= 1'b1;
    end else if (level > wm_level) begin
      irq_wm <= 1'b0;
    end
  end
`else
  assign irq_wm = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench for uart_tx_fifo_ctrl with behavioural FIFO and TX shifter models.
// Define UART_TX_WATERMARK_EN to also exercise the watermark interrupt.
module tb_uart_tx_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 0;
  logic              reset = 0;
  logic              cpu_wr = 0;
  logic [DATA_W-1:0] cpu_wdata = 0;
  logic              tx_en = 0;
  logic              ovf_clr = 0;
  logic              cpu_wready, overflow, drained, irq_wm;
  logic [CNT_W-1:0]  level;
  logic              fifo_writeEn, fifo_readEn, fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_dataIn, tx_data;
  logic [DATA_W-1:0] fifo_dataOut = 0;
  logic              tx_start;
  logic              tx_busy = 0;
  logic              tx_done = 0;
`ifdef UART_TX_WATERMARK_EN
  logic [CNT_W-1:0]  wm_level = 2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .tx_en(tx_en),
    .cpu_wready(cpu_wready), .overflow(overflow), .ovf_clr(ovf_clr), .level(level),
    .drained(drained),
`ifdef UART_TX_WATERMARK_EN
    .wm_level(wm_level),
`endif
    .fifo_writeEn(fifo_writeEn), .fifo_dataIn(fifo_dataIn), .fifo_readEn(fifo_readEn),
    .fifo_dataOut(fifo_dataOut), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .irq_wm(irq_wm)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data appears on dataOut the cycle after readEn
  logic [DATA_W-1:0] fq[$];
  int fcount = 0;
  assign fifo_empty = (fcount == 0);
  assign fifo_full  = (fcount == DEPTH);

  always @(posedge clk) begin
    if (!reset) begin
      fq.delete();
      fifo_dataOut <= 0;
      fcount <= 0;
    end else begin
      if (fifo_readEn && fq.size() > 0) fifo_dataOut <= fq.pop_front();
      if (fifo_writeEn) fq.push_back(fifo_dataIn);
      fcount <= fq.size();
    end
  end

  // TX shifter model: busy for a random frame length, then a one-cycle done pulse
  int sh_cnt = 0;
  always @(posedge clk) begin
    tx_done <= 0;
    if (!reset) begin
      tx_busy <= 0;
      sh_cnt  <= 0;
    end else if (tx_start) begin
      tx_busy <= 1;
      sh_cnt  <= $urandom_range(1, 4);
    end else if (tx_busy) begin
      if (sh_cnt == 0) begin
        tx_busy <= 0;
        tx_done <= 1;
      end else begin
        sh_cnt <= sh_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [DATA_W-1:0] d, input logic en, input logic clr);
    @(posedge clk);
    #1;
    cpu_wr = wr;
    cpu_wdata = d;
    tx_en = en;
    ovf_clr = clr;
  endtask

  // Reference model and scoreboard, evaluated once per cycle
  bit                mon_en = 0;
  int                lvl_exp = 0;
  bit                ovf_exp = 0;
  bit                irq_exp = 0;
  bit                in_frame = 0;
  bit                holding = 0;
  bit                exp_rd = 0;
  bit                nxt_rd;
  int                since_rd = 99;
  int                cyc = 0;
  int                last_done = -1;
  int                gaps[$];
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] held = 0;
  logic [DATA_W-1:0] exp_byte;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      since_rd++;
      checkOutput("level", level, lvl_exp);
      checkOutput("overflow", overflow, ovf_exp);
      checkOutput("cpu_wready", cpu_wready, !fifo_full);
      checkOutput("fifo_writeEn", fifo_writeEn, cpu_wr && !fifo_full);
      if (cpu_wr) checkOutput("fifo_dataIn", fifo_dataIn, cpu_wdata);
      checkOutput("fifo_readEn", fifo_readEn, exp_rd);
      if (exp_rd) begin
        in_frame = 1;
        since_rd = 0;
      end
      checkOutput("drained", drained, fifo_empty && !in_frame);
      checkOutput("tx_start", tx_start, since_rd == 2);
      if (since_rd == 2) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("[TB] FAIL sb_order: tx_start with no byte expected, got %0h", tx_data);
        end else begin
          exp_byte = sb.pop_front();
          if (tx_data !== exp_byte) begin
            n_errors++;
            $display("[TB] FAIL tx_data: got %0h, expected %0h at %0t", tx_data, exp_byte, $time);
          end
          held = exp_byte;
          holding = 1;
        end
        if (last_done >= 0) gaps.push_back(cyc - last_done - 1);
      end else if (holding) begin
        checkOutput("tx_data_hold", tx_data, held);
      end
`ifdef UART_TX_WATERMARK_EN
      checkOutput("irq_wm", irq_wm, irq_exp);
      if (lvl_exp <= int'(wm_level) && tx_en) irq_exp = 1;
      else if (lvl_exp > int'(wm_level)) irq_exp = 0;
`else
      checkOutput("irq_wm", irq_wm, 0);
`endif
      nxt_rd = !in_frame && tx_en && !fifo_empty && !tx_busy;
      if (tx_done) begin
        in_frame = 0;
        holding = 0;
        last_done = cyc;
      end
      if (cpu_wr && !fifo_full) sb.push_back(cpu_wdata);
      lvl_exp = lvl_exp + ((cpu_wr && !fifo_full) ? 1 : 0) - (exp_rd ? 1 : 0);
      if (cpu_wr && fifo_full) ovf_exp = 1;
      else if (ovf_clr) ovf_exp = 0;
      exp_rd = nxt_rd;
      if (!reset) begin
        lvl_exp = 0; ovf_exp = 0; irq_exp = 0; in_frame = 0; holding = 0;
        exp_rd = 0; since_rd = 99; last_done = -1; sb.delete();
      end
    end
  end

  task automatic waitDrained();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (drained) break;
    end
    checkOutput("drain_timeout", drained, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset held for three cycles
    reset = 0;
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_drained", drained, 1);
    checkOutput("rst_tx_data", tx_data, 0);

    // Three bytes held while paused, then drained in order
    applyStimulus(1, 8'hA5, 0, 0);
    applyStimulus(1, 8'h3C, 0, 0);
    applyStimulus(1, 8'hFF, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("paused_level", level, 3);
    checkOutput("paused_no_read", fifo_readEn, 0);
    gaps.delete();
    last_done = -1;
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("read_not_yet", fifo_readEn, 0);
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("read_pulse", fifo_readEn, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("first_start", tx_start, 1);
    checkOutput("first_byte", tx_data, 8'hA5);
    waitDrained();
    checkOutput("gap_count", gaps.size(), 2);
    if (gaps.size() > 0) checkOutput("b2b_idle_cycles", gaps[0], 3);

    // Nine writes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) applyStimulus(1, 8'($urandom), 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_level", level, 8);
    checkOutput("full_wready", cpu_wready, 0);
    checkOutput("ovf_set", overflow, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("ovf_cleared", overflow, 0);
    applyStimulus(0, 0, 1, 0);
    waitDrained();

    // Write coinciding with a FIFO read keeps the level
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'($urandom), 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 8'h5A, 1, 0);
    @(negedge clk);
    checkOutput("simul_read", fifo_readEn, 1);
    checkOutput("simul_write", fifo_writeEn, 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("simul_level", level, 4);

    // Random traffic with tx_en toggling
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'($urandom), 1'($urandom), 0);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        applyStimulus(0, 0, 1'($urandom), 0);
    end
    applyStimulus(0, 0, 1, 0);
    waitDrained();

    // Reset during SEND aborts the frame
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'($urandom), 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start) break;
    end
    checkOutput("start_seen", tx_start, 1);
    @(posedge clk); #1;
    tx_en = 0;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    checkOutput("abort_tx_data", tx_data, 0);
    checkOutput("abort_level", level, 0);
    checkOutput("abort_tx_start", tx_start, 0);
    checkOutput("abort_drained", drained, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort_no_start", tx_start, 0);

`ifdef UART_TX_WATERMARK_EN
    // Watermark at 2 while a five-byte burst drains
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'($urandom), 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wm_high_level", irq_wm, 0);
    applyStimulus(0, 0, 1, 0);
    waitDrained();
    checkOutput("wm_low_level", irq_wm, 1);
`endif

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Sequences the UART transmit path: accepts CPU bytes into the TX FIFO, drains the FIFO one byte at a time into the UART transmitter, and reports level, overflow and drain status. Sits between the CPU-side UART register interface, the FIFO_Buffer instance (clk/reset/writeEn/readEn/dataIn/dataOut/EMPTY/FULL) and the UART TX shifter.

Parameters:
DATA_W, 8, byte width on all data paths
DEPTH, 8, FIFO depth; must match the attached FIFO_Buffer
CNT_W, 4, level counter width; must hold 0..DEPTH
GAP_CYCLES, 0, idle clocks inserted between tx_done and the next FIFO read

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous active-low reset
cpu_wr  in  1  CPU write strobe, one byte per cycle
cpu_wdata  in  DATA_W  CPU byte
tx_en  in  1  drain enable; 0 pauses draining without losing data
cpu_wready  out  1  equals !fifo_full
overflow  out  1  sticky: write attempted while full; cleared by ovf_clr
ovf_clr  in  1  clears overflow
level  out  CNT_W  bytes currently held in the FIFO
drained  out  1  high when FIFO empty and FSM in IDLE
fifo_writeEn  out  1  to FIFO writeEn
fifo_dataIn  out  DATA_W  to FIFO dataIn
fifo_readEn  out  1  to FIFO readEn
fifo_dataOut  in  DATA_W  from FIFO dataOut, valid 1 cycle after readEn
fifo_empty  in  1  from FIFO EMPTY
fifo_full  in  1  from FIFO FULL
tx_start  out  1  1-cycle pulse: load tx_data into the shifter
tx_data  out  DATA_W  byte for the shifter, held stable from tx_start to tx_done
tx_busy  in  1  shifter busy
tx_done  in  1  1-cycle pulse at end of stop bit
irq_wm  out  1  watermark interrupt (optional feature only)

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE, level=0, overflow=0, tx_start=0, tx_data=0, fifo_readEn=0, gap counter=0, irq_wm=0. Reset asserted mid-frame aborts the frame at the next edge; the byte held in tx_data is lost. The FIFO shares the same reset, so contents are also lost.
- Write path, combinational: fifo_writeEn = cpu_wr & !fifo_full; fifo_dataIn = cpu_wdata. If cpu_wr & fifo_full, the byte is dropped and overflow is set next cycle. If ovf_clr and a new overflow occur in the same cycle, overflow is set (set wins).
- level: +1 on an accepted write; -1 on fifo_readEn; unchanged when both occur in the same cycle. Never wraps; the range is 0..DEPTH.
- FSM states:
  - IDLE: if tx_en & !fifo_empty & !tx_busy, assert fifo_readEn for 1 cycle and go to FETCH.
  - FETCH: wait 1 cycle for FIFO read latency, then go to LOAD.
  - LOAD: register tx_data <= fifo_dataOut, pulse tx_start, go to SEND.
  - SEND: on tx_done go to GAP if GAP_CYCLES>0, otherwise to IDLE.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- Dropping tx_en stops only new fetches. A byte already in FETCH, LOAD or SEND completes.
- fifo_readEn is never asserted while fifo_empty=1, and never more than once per byte.
- Throughput with GAP_CYCLES=0: IDLE to tx_start takes 2 cycles; back-to-back bytes are separated by 3 cycles after tx_done.
- drained = fifo_empty & (state==IDLE).
- A simultaneous CPU write and FIFO read in the same cycle are both honoured.

Optional Feature:
- Macro: UART_TX_WATERMARK_EN.
- With the macro defined:
  - Adds input wm_level[CNT_W-1:0].
  - irq_wm is a registered level signal, set when level <= wm_level and tx_en=1, and cleared when level > wm_level.
- Without the macro: no wm_level port, and irq_wm is tied to 0.

Test Plan:
1. Reset low 3 cycles, then high -> level=0, overflow=0, tx_start=0, drained=1.
2. tx_en=0; write 0xA5, 0x3C, 0xFF -> level=3, no fifo_readEn. Set tx_en=1 with tx_busy=0 -> readEn asserted; tx_start 2 cycles later with tx_data=0xA5. After tx_done, the next byte 0x3C follows 3 cycles later.
3. Write 9 bytes with DEPTH=8 and tx_en=0 -> level=8, cpu_wready=0, overflow=1 after the 9th byte. Pulse ovf_clr -> overflow=0.
4. Simultaneous cpu_wr and fifo_readEn at level=4 -> level remains 4. Draining 20 random bytes -> output order equals input order.
5. Reset asserted during SEND -> next cycle FSM=IDLE, tx_data=0, level=0, with no tx_start.
6. UART_TX_WATERMARK_EN defined, wm_level=2, tx_en=1 -> irq_wm=0 at level 5, irq_wm=1 one cycle after level reaches 2.
